// File: rtl/sy89297_serial_rx.sv
// SY89297 3-wire programming receiver: oversamples sclk/sdata/sload in the clk domain,
// rebuilds the {B,A} frame and commits it on the sload rising edge.
module sy89297_serial_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              sload,
  output logic [DATA_W-1:0] dataa_out,
  output logic [DATA_W-1:0] datab_out,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);
  localparam int FW   = 2 * DATA_W;
  localparam int CW   = $clog2(FW + 2);
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
  logic [SYNC_STAGES-1:0] sload_sync_q, sload_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sdata_prev_q, sdata_prev_d;
  logic                   sload_prev_q, sload_prev_d;
  logic                   rise_sclk_q, rise_sclk_d;
  logic                   rise_sload_q, rise_sload_d;
  logic [FW-1:0]          shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]      dataa_q, dataa_d, datab_q, datab_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   do_shift;

  // Rise pulses are registered so the commit lands SYNC_STAGES+1 edges after sload is sampled;
  // sdata_prev_q is the sdata bit aligned with rise_sclk_q.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
    sload_sync_d = {sload_sync_q[SYNC_STAGES-2:0], sload};
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
    sdata_prev_d = sdata_sync_q[SYNC_STAGES-1];
    sload_prev_d = sload_sync_q[SYNC_STAGES-1];
    rise_sclk_d  = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    rise_sload_d = sload_sync_q[SYNC_STAGES-1] & ~sload_prev_q;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    dataa_d   = dataa_q;
    datab_d   = datab_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    // sclk edges are ignored while sload is held high (but not on sload's own rising cycle)
    do_shift  = rise_sclk_q & ~(sload_prev_q & ~rise_sload_q);

    if (do_shift) begin
      shift_d   = {shift_q[FW-2:0], sdata_prev_q};
      bit_cnt_d = (bit_cnt_q == CW'(FW + 1)) ? bit_cnt_q : bit_cnt_q + 1'b1;
      to_cnt_d  = '0;
      state_d   = SHIFT;
    end else if (state_q == SHIFT) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        err_d     = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (rise_sload_q) begin
      if (bit_cnt_d == CW'(FW)) begin
        valid_d = 1'b1;
        err_d   = 1'b0;
        datab_d = shift_d[FW-1:DATA_W];
        dataa_d = shift_d[DATA_W-1:0];
      end else begin
        err_d = 1'b1;
      end
      bit_cnt_d = '0;
      to_cnt_d  = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      sload_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
      sdata_prev_q <= 1'b0;
      sload_prev_q <= 1'b0;
      rise_sclk_q  <= 1'b0;
      rise_sload_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      dataa_q      <= '0;
      datab_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
      sload_sync_q <= sload_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      sdata_prev_q <= sdata_prev_d;
      sload_prev_q <= sload_prev_d;
      rise_sclk_q  <= rise_sclk_d;
      rise_sload_q <= rise_sload_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      dataa_q      <= dataa_d;
      datab_q      <= datab_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign dataa_out = dataa_q;
  assign datab_out = datab_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q == SHIFT);
endmodule

// File: tb/tb_sy89297_serial_rx.sv
// Directed bench for sy89297_serial_rx: good, short, overrun, timeout,
// coincident sclk/sload and mid-frame reset scenarios.
module tb_sy89297_serial_rx;
  logic       clk, rst, sclk, sdata, sload;
  logic [9:0] dataa_out, datab_out;
  logic       valid, frame_err, busy;
  int         n_cmp, n_bad;

  sy89297_serial_rx #(.SYNC_STAGES(2), .DATA_W(10), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdata(sdata), .sload(sload),
    .dataa_out(dataa_out), .datab_out(datab_out), .valid(valid),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sclk = clk/8, MSB first, inputs changed on the falling clk edge
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdata = bits[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Raise sload (optionally together with the final sclk rise) and check the single result pulse
  task automatic do_load(input string tag, input logic exp_valid, input logic with_sclk);
    int   lat;
    logic v, e, after;
    lat = -1; v = 1'b0; e = 1'b0; after = 1'b0;
    sload = 1'b1;
    if (with_sclk) sclk = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (lat < 0 && (valid || frame_err)) begin
        lat = k - 1; v = valid; e = frame_err;
      end else if (lat >= 0 && lat == k - 2) begin
        after = valid | frame_err;
      end
      if (k == 6) sclk = 1'b0;
    end
    sload = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_valid"}, v, exp_valid);
    chk({tag, "_err"}, e, !exp_valid);
    chk({tag, "_width1"}, after, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic chk_data(input string tag, input logic [9:0] b, input logic [9:0] a);
    chk({tag, "_datab"}, datab_out, b);
    chk({tag, "_dataa"}, dataa_out, a);
  endtask

  initial begin
    int   cnt;
    logic spur;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; sclk = 1'b0; sdata = 1'b0; sload = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk_data("rst", 10'h000, 10'h000);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1: good frame
    send_bits({10'h2A5, 10'h15A}, 20);
    chk("t1_busy_mid", busy, 1);
    do_load("t1", 1'b1, 1'b0);
    chk_data("t1", 10'h2A5, 10'h15A);

    // 2: short frame
    send_bits({10'h3FF, 10'h001}, 20);
    do_load("t2a", 1'b1, 1'b0);
    chk_data("t2a", 10'h3FF, 10'h001);
    send_bits(32'h5_5555, 19);
    do_load("t2b", 1'b0, 1'b0);
    chk_data("t2b", 10'h3FF, 10'h001);

    // 3: overrun then clean frame
    send_bits(32'h2A_AAAA, 22);
    do_load("t3a", 1'b0, 1'b0);
    chk_data("t3a", 10'h3FF, 10'h001);
    send_bits({10'h000, 10'h3FF}, 20);
    do_load("t3b", 1'b1, 1'b0);
    chk_data("t3b", 10'h000, 10'h3FF);

    // sload with no bits while idle
    do_load("idle", 1'b0, 1'b0);
    chk_data("idle", 10'h000, 10'h3FF);

    // 4: timeout after 7 bits (last sclk rise was 4 clk cycles before the count starts)
    send_bits(32'h55, 7);
    chk("t4_busy", busy, 1);
    cnt = 0;
    while (!frame_err && cnt < 1200) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_seen", frame_err, 1);
    chk("t4_window", (cnt >= 1000 && cnt <= 1040), 1);
    @(negedge clk);
    chk("t4_width1", frame_err, 0);
    chk("t4_busy_after", busy, 0);
    chk_data("t4", 10'h000, 10'h3FF);
    send_bits({10'h1C3, 10'h0A7}, 20);
    do_load("t4b", 1'b1, 1'b0);
    chk_data("t4b", 10'h1C3, 10'h0A7);

    // 5: 20th sclk rise and sload rise together
    send_bits({10'h0F3, 10'h2CC} >> 1, 19);
    sdata = 1'b0;
    repeat (4) @(negedge clk);
    do_load("t5", 1'b1, 1'b1);
    chk_data("t5", 10'h0F3, 10'h2CC);

    // 6: reset mid-frame
    send_bits(32'hABC, 12);
    rst = 1'b0;
    #1;
    chk_data("t6_async", 10'h000, 10'h000);
    chk("t6_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    spur = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      spur |= valid | frame_err;
    end
    chk("t6_no_spurious", spur, 0);
    send_bits({10'h123, 10'h0F0}, 20);
    do_load("t6", 1'b1, 1'b0);
    chk_data("t6", 10'h123, 10'h0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
